iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set operand and result width (legal 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand/op transaction offered.
REQ-005 in_ready  output  1  block can accept a transaction.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select (encoding per REQ-012).
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result; carry output 1 bit; zero output 1 bit.

Function
REQ-012 op encoding SHALL be: 000 two's-complement of A, 001 two's-complement of B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 low WIDTH bits of A*B, 111 high WIDTH bits of A*B.
REQ-013 Arithmetic SHALL be unsigned modulo 2^WIDTH; product is full 2*WIDTH bits before selection.
REQ-014 carry SHALL be the adder carry-out for 010, the borrow (A<B) for 011, (A==0) inverted for 000/001 negation (i.e. 1 when operand nonzero), and 0 for all other ops.
REQ-015 zero SHALL be 1 exactly when result==0.
REQ-016 FSM states SHALL be IDLE, MUL, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a transaction is accepted on the edge where in_valid&&in_ready.
REQ-018 Accept of ops 000..101 SHALL register result/flags and enter DONE on that same edge (latency 1: out_valid high the cycle after accept).
REQ-019 Accept of op 110/111 SHALL capture A, B, op and enter MUL; shift-add performs one partial-product step per cycle for exactly WIDTH cycles, then enters DONE (out_valid high WIDTH+1 cycles after accept edge).
REQ-020 In DONE out_valid SHALL be 1 and result, carry, zero SHALL hold stable until out_valid&&out_ready.
REQ-021 On out_valid&&out_ready the FSM SHALL return to IDLE; no new accept in that same cycle (in_ready still 0).
REQ-022 Operand/op inputs SHALL be ignored outside the accept edge; changes during MUL/DONE do not affect the result.
REQ-023 out_ready held low SHALL stall indefinitely in DONE with no loss of result.
REQ-024 Multiplication of any value by 0 SHALL still take WIDTH cycles (fixed latency).

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, result 0, carry 0, zero 0, out_valid 0, in_ready 1 after release, and clear multiplier accumulator/counter.
REQ-026 Reset asserted mid-MUL or in DONE SHALL abandon the operation; no out_valid for it after release.

Structure
REQ-027 Op encodings and FSM state enum SHALL reside in shared package alu_pkg.
REQ-028 Iterative multiplier SHALL be sub-module shift_add_mul (start, A, B in; done, 2*WIDTH product out; WIDTH-cycle fixed latency).
REQ-029 Adder/subtract/logic path SHALL be combinational within iter_alu feeding the result register.

Verification
REQ-030 WIDTH=4, op 010, A=1111 B=0001 -> result 0000, carry 1, zero 1, out_valid one cycle after accept.
REQ-031 WIDTH=4, op 011, A=0000 B=1101 -> result 0011, carry 1; A=0101 B=0100 -> 0001, carry 0.
REQ-032 WIDTH=4, op 110 then 111, A=0110 B=1111 -> 1010 then 0101, each out_valid exactly 5 cycles after accept; in_ready 0 throughout.
REQ-033 WIDTH=4, op 000 A=0001 with out_ready held 0 for 10 cycles -> result 1111 carry 1 stable, out_valid 1 all 10 cycles, released on out_ready.
REQ-034 WIDTH=4, reset pulsed 2 cycles into op 110 -> out_valid stays 0, in_ready 1 after release, next op 100 A=1010 B=0101 -> 0000, zero 1.
REQ-035 WIDTH=8, op 111 then 110, A=B=0xFF -> 0xFE then 0x01, out_valid 9 cycles after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and controller-state definitions for the iterative ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NEG_A  = 3'b000,
    OP_NEG_B  = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_MUL_LO = 3'b110,
    OP_MUL_HI = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Both multiply encodings share the 11x prefix.
  function automatic logic is_mul_op(input logic [2:0] op_v);
    return op_v[2] & op_v[1];
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, fixed WIDTH-cycle latency.
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i) begin
      // The first step is folded into the load edge so the result lands WIDTH edges later.
      prod_d  = mul_step({{WIDTH{1'b0}}, b_i}, a_i);
      mcand_d = a_i;
      cnt_d   = CW'(WIDTH - 1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        prod_d = mul_step(prod_q, mcand_q);
        cnt_d  = cnt_q - CW'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = prod_q;

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/negate, WIDTH-cycle iterative multiply.
//   state   | meaning
//   ST_IDLE | in_ready high, waiting for a transaction
//   ST_MUL  | shift-add multiplier running
//   ST_DONE | out_valid high, result held until out_ready
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     add_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH-1:0]   mul_sel;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul_op(op);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    case (alu_op_e'(op))
      OP_NEG_A: begin alu_res = -a;    alu_c = (a != '0); end
      OP_NEG_B: begin alu_res = -b;    alu_c = (b != '0); end
      OP_ADD:   begin alu_res = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
      OP_SUB:   begin alu_res = a - b; alu_c = (a < b); end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      default:  alu_res = '0;
    endcase
  end

  assign mul_sel = (op_q == OP_MUL_HI) ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_op(op)) begin
            op_d    = alu_op_e'(op);
            state_d = ST_MUL;
          end else begin
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = (alu_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d = mul_sel;
          carry_d  = 1'b0;
          zero_d   = (mul_sel == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NEG_A;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: one WIDTH=4 and one WIDTH=8 instance on a shared clock/reset.
module tb_iter_alu;

  logic clk;
  logic rst_n;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, carry4, zero4;
  logic [3:0] a4, b4, res4;
  logic [2:0] op4;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, carry8, zero8;
  logic [7:0] a8, b8, res8;
  logic [2:0] op8;

  int checks = 0;
  int errors = 0;

  logic       sel8;
  logic       in_ready_m, out_valid_m, carry_m, zero_m;
  logic [7:0] res_m;

  assign in_ready_m  = sel8 ? in_ready8  : in_ready4;
  assign out_valid_m = sel8 ? out_valid8 : out_valid4;
  assign carry_m     = sel8 ? carry8     : carry4;
  assign zero_m      = sel8 ? zero8      : zero4;
  assign res_m       = sel8 ? res8       : {4'h0, res4};

  iter_alu #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(res4), .carry(carry4), .zero(zero4)
  );

  iter_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(res8), .carry(carry8), .zero(zero8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input bit w8, input logic [2:0] op_v, input logic [7:0] a_v,
                         input logic [7:0] b_v, input logic [7:0] exp_res, input logic exp_c,
                         input int exp_lat, input int stall);
    int lat;
    bit rdy_ok, hold_ok;
    logic [7:0] held;
    sel8 = w8;
    @(negedge clk);
    chk("in_ready_idle", in_ready_m, 1);
    if (w8) begin op8 = op_v; a8 = a_v; b8 = b_v; in_valid8 = 1'b1; end
    else begin op4 = op_v; a4 = a_v[3:0]; b4 = b_v[3:0]; in_valid4 = 1'b1; end
    @(posedge clk);
    #1;
    // Scramble operands after accept; the held result must not follow them.
    in_valid4 = 1'b0; in_valid8 = 1'b0;
    a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8; op4 = ~op4; op8 = ~op8;
    lat = 0;
    rdy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid_m && in_ready_m) rdy_ok = 1'b0;
    end while (!out_valid_m && lat < 40);
    chk("ready_low_busy", rdy_ok, 1);
    chk("latency", lat, exp_lat);
    chk("result", res_m, exp_res);
    chk("carry", carry_m, exp_c);
    chk("zero", zero_m, exp_res == 8'h00);
    held = res_m;
    hold_ok = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid_m || in_ready_m || res_m !== held || carry_m !== exp_c) hold_ok = 1'b0;
    end
    if (stall > 0) chk("stall_hold", hold_ok, 1);
    if (w8) out_ready8 = 1'b1; else out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0; out_ready8 = 1'b0;
    @(negedge clk);
    chk("released_valid", out_valid_m, 0);
    chk("released_ready", in_ready_m, 1);
  endtask

  initial begin
    bit seen;
    clk = 1'b0; rst_n = 1'b1; sel8 = 1'b0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; op4 = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; op8 = 0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid4", out_valid4, 0);
    chk("rst_result4", res4, 0);
    chk("rst_carry4", carry4, 0);
    chk("rst_zero4", zero4, 0);
    chk("rst_valid8", out_valid8, 0);
    chk("rst_result8", res8, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready4", in_ready4, 1);
    chk("rst_ready8", in_ready8, 1);

    //      w8  op      a      b      exp    c  lat stall
    run_txn(0, 3'b010, 8'hF, 8'h1, 8'h0, 1, 1, 0);
    run_txn(0, 3'b011, 8'h0, 8'hD, 8'h3, 1, 1, 0);
    run_txn(0, 3'b011, 8'h5, 8'h4, 8'h1, 0, 1, 0);
    run_txn(0, 3'b110, 8'h6, 8'hF, 8'hA, 0, 5, 0);
    run_txn(0, 3'b111, 8'h6, 8'hF, 8'h5, 0, 5, 0);
    run_txn(0, 3'b000, 8'h1, 8'h7, 8'hF, 1, 1, 10);
    run_txn(0, 3'b001, 8'h3, 8'h0, 8'h0, 0, 1, 0);
    run_txn(0, 3'b001, 8'h3, 8'h6, 8'hA, 1, 1, 0);
    run_txn(0, 3'b101, 8'hA, 8'h5, 8'hF, 0, 1, 0);
    run_txn(0, 3'b110, 8'h0, 8'h9, 8'h0, 0, 5, 3);
    run_txn(0, 3'b111, 8'hF, 8'hF, 8'hE, 0, 5, 0);

    // Reset two cycles into a multiply: the operation must vanish.
    sel8 = 1'b0;
    @(negedge clk);
    op4 = 3'b110; a4 = 4'h6; b4 = 4'hF; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_rst_valid", out_valid4, 0);
    chk("midmul_rst_result", res4, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid4) seen = 1'b1;
    end
    chk("abandoned_valid", seen, 0);
    chk("after_rst_ready", in_ready4, 1);
    run_txn(0, 3'b100, 8'hA, 8'h5, 8'h0, 0, 1, 0);

    run_txn(1, 3'b111, 8'hFF, 8'hFF, 8'hFE, 0, 9, 0);
    run_txn(1, 3'b110, 8'hFF, 8'hFF, 8'h01, 0, 9, 0);
    run_txn(1, 3'b010, 8'hC8, 8'h64, 8'h2C, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
